// File: rtl/decode_issue.sv
// Decode/issue stage feeding the 8-bit ALU.
// Holds the register file, a per-register pending-write scoreboard and a single
// registered valid/ready output slot. Write-back data is bypassed into same-cycle reads.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   instr_valid/instr       instruction offered by fetch
//   instr_ready             combinational accept indication back to fetch
//   wb_en/wb_addr/wb_data   register write-back
//   flush                   taken branch: squash held slot and offered instruction
//   ex_valid/ex_ready       output slot handshake towards the ALU
//   reg1/reg2/func/spec_fun ALU operands and function
//   dst_addr/dst_we         destination register and write flag
//   illegal                 one-cycle pulse with an issued undefined func
module decode_issue #(
  parameter int unsigned NREG = 8,
  parameter int unsigned IW   = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    instr_valid,
  input  logic [IW-1:0]           instr,
  output logic                    instr_ready,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [7:0]              wb_data,
  input  logic                    flush,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [7:0]              reg1,
  output logic [7:0]              reg2,
  output logic [3:0]              func,
  output logic [2:0]              spec_fun,
  output logic [$clog2(NREG)-1:0] dst_addr,
  output logic                    dst_we,
  output logic                    illegal
);

  localparam int unsigned AW = $clog2(NREG);

  logic [7:0]      r_rf [NREG];
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_d;

  logic            r_ex_valid;
  logic [7:0]      r_reg1;
  logic [7:0]      r_reg2;
  logic [3:0]      r_func;
  logic [2:0]      r_spec;
  logic [AW-1:0]   r_dst;
  logic            r_dst_we;
  logic            r_illegal;

  logic [3:0]      w_func_in;
  logic [AW-1:0]   w_ra;
  logic [AW-1:0]   w_rb;
  logic            w_writer;
  logic            w_branch;
  logic            w_illegal;
  logic            w_use_a;
  logic            w_use_b;
  logic            w_imm;
  logic            w_byp_a;
  logic            w_byp_b;
  logic [7:0]      w_rd_a;
  logic [7:0]      w_rd_b;
  logic            w_hazard;
  logic            w_accept;

  assign w_func_in = instr[11:8];
  assign w_ra      = instr[7:5];
  assign w_rb      = instr[4:2];

  always_comb begin
    w_writer = 1'b0;
    w_branch = 1'b0;
    w_use_b  = 1'b0;
    case (w_func_in)
      4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB: w_writer = 1'b1;
      4'hC, 4'hD:                                     w_branch = 1'b1;
      default:                                        ;
    endcase
    case (w_func_in)
      4'h0, 4'h3, 4'h4, 4'h5, 4'hC, 4'hD: w_use_b = 1'b1;
      default:                            ;
    endcase
  end

  assign w_illegal = !w_writer && !w_branch;
  assign w_use_a   = (w_func_in != 4'h5);
  // slw/shg take the low nibble as an immediate second operand
  assign w_imm     = (w_func_in == 4'hA) || (w_func_in == 4'hB);

  assign w_byp_a = wb_en && (wb_addr == w_ra);
  assign w_byp_b = wb_en && (wb_addr == w_rb);
  assign w_rd_a  = w_byp_a ? wb_data : r_rf[w_ra];
  assign w_rd_b  = w_byp_b ? wb_data : r_rf[w_rb];

  // A pending source is not a hazard if its write-back lands this very cycle.
  assign w_hazard = (w_use_a && r_pend[w_ra] && !w_byp_a) ||
                    (w_use_b && r_pend[w_rb] && !w_byp_b);

  assign instr_ready = flush || (!w_hazard && (!r_ex_valid || ex_ready));
  assign w_accept    = instr_valid && instr_ready && !flush;

  // Order matters: clears first, then the set, so a same-cycle set wins.
  always_comb begin
    w_pend_d = r_pend;
    if (flush && r_ex_valid && r_dst_we && !ex_ready) begin
      w_pend_d[r_dst] = 1'b0;
    end
    if (wb_en) begin
      w_pend_d[wb_addr] = 1'b0;
    end
    if (w_accept && w_writer) begin
      w_pend_d[w_ra] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_en) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_reg1     <= '0;
      r_reg2     <= '0;
      r_func     <= '0;
      r_spec     <= '0;
      r_dst      <= '0;
      r_dst_we   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= w_accept && w_illegal;
      if (flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_accept) begin
        r_ex_valid <= 1'b1;
        r_reg1     <= w_rd_a;
        r_reg2     <= w_imm ? {4'b0, instr[3:0]} : w_rd_b;
        r_func     <= w_illegal ? 4'hF : w_func_in;
        r_spec     <= instr[2:0];
        r_dst      <= w_ra;
        r_dst_we   <= w_writer;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign reg1     = r_reg1;
  assign reg2     = r_reg2;
  assign func     = r_func;
  assign spec_fun = r_spec;
  assign dst_addr = r_dst;
  assign dst_we   = r_dst_we;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: expected issue results are pushed on acceptance
// and popped when the output slot loads.
module tb_decode_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [11:0] instr;
  logic        instr_ready;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [7:0]  reg1;
  logic [7:0]  reg2;
  logic [3:0]  func;
  logic [2:0]  spec_fun;
  logic [2:0]  dst_addr;
  logic        dst_we;
  logic        illegal;

  decode_issue dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .reg1        (reg1),
    .reg2        (reg2),
    .func        (func),
    .spec_fun    (spec_fun),
    .dst_addr    (dst_addr),
    .dst_we      (dst_we),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] r1;
    logic [7:0] r2;
    logic [3:0] f;
    logic [2:0] sf;
    logic [2:0] da;
    logic       we;
    logic       il;
  } exp_t;

  exp_t       q[$];
  exp_t       m_slot;
  logic       m_ev;
  logic [7:0] m_rf [8];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [11:0] ins, input logic wbe,
                                 input logic [2:0] wba, input logic [7:0] wbd);
    exp_t       e;
    logic [3:0] f;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] va;
    logic [7:0] vb;
    f  = ins[11:8];
    ra = ins[7:5];
    rb = ins[4:2];
    va = (wbe && wba == ra) ? wbd : m_rf[ra];
    vb = (wbe && wba == rb) ? wbd : m_rf[rb];
    e.r1 = va;
    e.r2 = (f == 4'hA || f == 4'hB) ? {4'h0, ins[3:0]} : vb;
    e.sf = ins[2:0];
    e.da = ra;
    e.f  = f;
    e.we = 1'b0;
    e.il = 1'b0;
    case (f)
      4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB: e.we = 1'b1;
      4'hC, 4'hD: e.we = 1'b0;
      default: begin
        e.f  = 4'hF;
        e.il = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic step(input string tag, input logic v, input logic [11:0] ins,
                      input logic wbe, input logic [2:0] wba, input logic [7:0] wbd,
                      input logic fl, input logic er, input logic exp_rdy);
    logic acc;
    logic il_exp;
    @(negedge clock);
    instr_valid = v;
    instr       = ins;
    wb_en       = wbe;
    wb_addr     = wba;
    wb_data     = wbd;
    flush       = fl;
    ex_ready    = er;
    #1;
    chk($sformatf("%s.ready", tag), 8'(instr_ready), 8'(exp_rdy));
    acc = v && exp_rdy && !fl;
    if (acc) q.push_back(model(ins, wbe, wba, wbd));
    @(posedge clock);
    if (wbe) m_rf[wba] = wbd;
    if (fl) m_ev = 1'b0;
    else if (acc) m_ev = 1'b1;
    else if (er) m_ev = 1'b0;
    #1;
    il_exp = 1'b0;
    if (acc && q.size() > 0) begin
      m_slot = q.pop_front();
      il_exp = m_slot.il;
    end
    chk($sformatf("%s.ex_valid", tag), 8'(ex_valid), 8'(m_ev));
    chk($sformatf("%s.illegal", tag), 8'(illegal), 8'(il_exp));
    if (m_ev) begin
      chk($sformatf("%s.reg1", tag), reg1, m_slot.r1);
      chk($sformatf("%s.reg2", tag), reg2, m_slot.r2);
      chk($sformatf("%s.func", tag), 8'(func), 8'(m_slot.f));
      chk($sformatf("%s.spec_fun", tag), 8'(spec_fun), 8'(m_slot.sf));
      chk($sformatf("%s.dst_addr", tag), 8'(dst_addr), 8'(m_slot.da));
      chk($sformatf("%s.dst_we", tag), 8'(dst_we), 8'(m_slot.we));
    end
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    flush       = 1'b0;
    ex_ready    = 1'b1;
    m_ev        = 1'b0;
    m_slot      = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    #12;
    chk("rst.ex_valid", 8'(ex_valid), 8'h00);
    chk("rst.reg1", reg1, 8'h00);
    chk("rst.reg2", reg2, 8'h00);
    chk("rst.func", 8'(func), 8'h00);
    chk("rst.spec_fun", 8'(spec_fun), 8'h00);
    chk("rst.dst_addr", 8'(dst_addr), 8'h00);
    chk("rst.dst_we", 8'(dst_we), 8'h00);
    chk("rst.illegal", 8'(illegal), 8'h00);
    chk("rst.ready", 8'(instr_ready), 8'h01);
    @(negedge clock);
    reset = 1'b0;

    //    tag           v  instr    wbe wba wbd    fl er rdy
    step("add_r1",     1, 12'h024, 0,  0,  8'h00, 0, 1, 1);
    step("wb_r3",      0, 12'h000, 1,  3,  8'hA5, 0, 1, 1);
    step("slw",        1, 12'hA66, 0,  0,  8'h00, 0, 1, 1);
    repeat (3) step("raw_stall", 1, 12'h024, 0, 0, 8'h00, 0, 1, 0);
    step("raw_bypass", 1, 12'h024, 1,  1,  8'h3C, 0, 1, 1);
    repeat (3) step("backpress", 1, 12'hC48, 0, 0, 8'h00, 0, 0, 0);
    step("branch",     1, 12'hC48, 0,  0,  8'h00, 0, 1, 1);
    step("wr_r4",      1, 12'h380, 0,  0,  8'h00, 0, 1, 1);
    step("flush",      1, 12'h800, 1,  6,  8'h77, 1, 0, 1);
    step("rd_r4",      1, 12'h3B0, 0,  0,  8'h00, 0, 1, 1);
    step("illegal",    1, 12'h8D8, 0,  0,  8'h00, 0, 1, 1);
    step("ill_gone",   0, 12'h000, 0,  0,  8'h00, 0, 1, 1);
    step("sb_r6",      1, 12'h0D8, 0,  0,  8'h00, 0, 1, 1);
    step("haz_r5",     1, 12'h0B4, 0,  0,  8'h00, 0, 1, 0);
    step("wb_r5",      1, 12'h0B4, 1,  5,  8'h5A, 0, 1, 1);

    // Asynchronous reset between edges with a valid slot held.
    @(negedge clock);
    instr_valid = 1'b0;
    wb_en       = 1'b0;
    ex_ready    = 1'b0;
    reset       = 1'b1;
    #1;
    chk("mid_rst.ex_valid", 8'(ex_valid), 8'h00);
    chk("mid_rst.reg1", reg1, 8'h00);
    chk("mid_rst.dst_we", 8'(dst_we), 8'h00);
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_ev = 1'b0;
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    step("post_rst",   1, 12'h0B4, 0,  0,  8'h00, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
